// File: rtl/conv_channel_accumulator.sv
// Multi-lane channel summer: pipelined adder tree, per-pixel group accumulation, bias add and saturation.
// Optional ReLU clamp on the output stage, enabled by defining CONV_CHAN_ACC_RELU_EN.
module conv_channel_accumulator #(
  parameter int unsigned NUM_IN      = 4,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned GROUP_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [GROUP_WIDTH-1:0]       num_groups_in,
  input  logic [DATA_WIDTH-1:0]        bias_in,
  input  logic                         clear_in,
  input  logic [NUM_IN*DATA_WIDTH-1:0] data_in,
  input  logic [NUM_IN-1:0]            valid_in,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         valid_out,
  output logic                         busy_out,
  output logic                         sat_out
);

  localparam int unsigned TREE_LVLS = $clog2(NUM_IN);
  localparam int unsigned TW        = DATA_WIDTH + TREE_LVLS;
  localparam int unsigned ACC_W     = TW + GROUP_WIDTH;
  localparam int unsigned SW        = ACC_W + 1;

  localparam logic signed [SW-1:0] SAT_MAX = {{(SW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {{(SW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  logic [TREE_LVLS:0] tree_vld_vec;

  // Adder tree: every level is padded to 2*NUM_IN entries; unused entries stay zero so an
  // odd leftover is simply added to zero, which is the registered pass-through.
  for (genvar k = 0; k <= TREE_LVLS; k++) begin : g_lvl
    logic signed [TW-1:0] s [2*NUM_IN];
    logic                 vld;

    if (k == 0) begin : g_in
      always_comb begin
        for (int j = 0; j < 2*NUM_IN; j++) s[j] = '0;
        for (int j = 0; j < NUM_IN; j++) begin
          if (valid_in[j]) s[j] = TW'($signed(data_in[j*DATA_WIDTH +: DATA_WIDTH]));
        end
        vld = |valid_in;
      end
    end else begin : g_add
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          vld <= 1'b0;
          for (int j = 0; j < 2*NUM_IN; j++) s[j] <= '0;
        end else begin
          vld <= g_lvl[k-1].vld & ~clear_in;
          for (int j = 0; j < NUM_IN; j++) s[j] <= g_lvl[k-1].s[2*j] + g_lvl[k-1].s[2*j+1];
          for (int j = NUM_IN; j < 2*NUM_IN; j++) s[j] <= '0;
        end
      end
    end

    assign tree_vld_vec[k] = vld;
  end

  logic signed [TW-1:0]    tree_sum;
  logic                    tree_vld;
  logic [GROUP_WIDTH-1:0]  grp_first;
  logic [GROUP_WIDTH-1:0]  grp_cnt;
  logic [GROUP_WIDTH-1:0]  grp_lat;
  logic signed [ACC_W-1:0] acc;
  logic                    fin;

  assign tree_sum  = g_lvl[TREE_LVLS].s[0];
  assign tree_vld  = g_lvl[TREE_LVLS].vld;
  assign grp_first = (num_groups_in == '0) ? GROUP_WIDTH'(1) : num_groups_in;

  // Group accumulation; the group count is captured on the first beat of each pixel.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc     <= '0;
      grp_cnt <= '0;
      grp_lat <= '0;
      fin     <= 1'b0;
    end else if (clear_in) begin
      acc     <= '0;
      grp_cnt <= '0;
      fin     <= 1'b0;
    end else begin
      fin <= 1'b0;
      if (tree_vld) begin
        if (grp_cnt == '0) begin
          acc     <= ACC_W'(tree_sum);
          grp_lat <= grp_first;
          if (grp_first == GROUP_WIDTH'(1)) fin <= 1'b1;
          else                              grp_cnt <= GROUP_WIDTH'(1);
        end else begin
          acc <= acc + ACC_W'(tree_sum);
          if (grp_cnt + GROUP_WIDTH'(1) == grp_lat) begin
            fin     <= 1'b1;
            grp_cnt <= '0;
          end else begin
            grp_cnt <= grp_cnt + GROUP_WIDTH'(1);
          end
        end
      end
    end
  end

  logic signed [SW-1:0]   pix_sum;
  logic [DATA_WIDTH-1:0]  pix_res;
  logic                   pix_clip;

  // Bias add and saturation; ReLU clamp is applied after saturation and never flags clipping.
  always_comb begin
    pix_sum  = {acc[ACC_W-1], acc} + {{(SW-DATA_WIDTH){bias_in[DATA_WIDTH-1]}}, bias_in};
    pix_clip = 1'b0;
    pix_res  = pix_sum[DATA_WIDTH-1:0];
    if (pix_sum > SAT_MAX) begin
      pix_res  = SAT_MAX[DATA_WIDTH-1:0];
      pix_clip = 1'b1;
    end else if (pix_sum < SAT_MIN) begin
      pix_res  = SAT_MIN[DATA_WIDTH-1:0];
      pix_clip = 1'b1;
    end
`ifdef CONV_CHAN_ACC_RELU_EN
    if (pix_res[DATA_WIDTH-1]) pix_res = '0;
`else
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out  <= '0;
      valid_out <= 1'b0;
      sat_out   <= 1'b0;
    end else if (clear_in) begin
      valid_out <= 1'b0;
      sat_out   <= 1'b0;
    end else begin
      valid_out <= fin;
      if (fin) begin
        data_out <= pix_res;
        if (pix_clip) sat_out <= 1'b1;
      end
    end
  end

  assign busy_out = (|(tree_vld_vec >> 1)) | (grp_cnt != '0) | fin;

endmodule

// File: tb/tb_conv_channel_accumulator.sv
// Directed bench for conv_channel_accumulator with a scoreboard of expected pixels and arrival cycles.
module tb_conv_channel_accumulator;

  localparam int unsigned NUM_IN = 4;
  localparam int unsigned DW     = 16;
  localparam int unsigned GW     = 8;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [GW-1:0]        num_groups;
  logic [DW-1:0]        bias;
  logic                 clear;
  logic [NUM_IN*DW-1:0] data;
  logic [NUM_IN-1:0]    valid;
  logic [DW-1:0]        data_out;
  logic                 valid_out;
  logic                 busy_out;
  logic                 sat_out;

  conv_channel_accumulator #(.NUM_IN(NUM_IN), .DATA_WIDTH(DW), .GROUP_WIDTH(GW)) dut (
    .clk(clk), .reset(rst_n), .num_groups_in(num_groups), .bias_in(bias), .clear_in(clear),
    .data_in(data), .valid_in(valid), .data_out(data_out), .valid_out(valid_out),
    .busy_out(busy_out), .sat_out(sat_out)
  );

  always #5 clk = ~clk;

  typedef struct { logic [DW-1:0] d; int c; } exp_t;
  exp_t sbq[$];
  int   cyc = 0;
  int   passed = 0;
  int   total = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Scoreboard consumer: every strobe must match the oldest expected pixel and its cycle.
  always @(negedge clk) begin
    if (rst_n && valid_out) begin
      if (sbq.size() == 0) begin
        chk("unexpected_strobe", 32'(data_out), 32'hDEAD_BEEF);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("pixel_data", 32'(data_out), 32'(e.d));
        chk("pixel_cycle", 32'(cyc), 32'(e.c));
      end
    end
  end

  task automatic beat(input int l0, input int l1, input int l2, input int l3,
                      input logic [3:0] v, input bit last, input int exp_val);
    data  = {16'(l3), 16'(l2), 16'(l1), 16'(l0)};
    valid = v;
    if (last) sbq.push_back('{d: 16'(exp_val), c: cyc + 4});
    @(posedge clk);
    #1;
    valid = '0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((busy_out || sbq.size() != 0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(n < 60), 32'd1);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int relu_exp;
    rst_n = 1'b0; num_groups = '0; bias = '0; clear = 1'b0; data = '0; valid = '0;
    #22;
    chk("rst_data", 32'(data_out), 0);
    chk("rst_valid", 32'(valid_out), 0);
    chk("rst_busy", 32'(busy_out), 0);
    chk("rst_sat", 32'(sat_out), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single group, no bias
    num_groups = 8'd1; bias = '0;
    beat(1, 2, 3, 4, 4'hF, 1, 10);
    chk("busy_after_beat", 32'(busy_out), 1);
    drain();

    // Three groups back-to-back with bias
    num_groups = 8'd3; bias = 16'd5;
    beat(1, 2, 3, 4, 4'hF, 0, 0);
    beat(-1, -1, -1, -1, 4'hF, 0, 0);
    beat(7, 0, 0, 0, 4'hF, 1, 18);
    drain();

    // Positive and negative saturation
    num_groups = 8'd2; bias = '0;
    beat(32'h7FFF, 32'h7FFF, 32'h7FFF, 32'h7FFF, 4'hF, 0, 0);
    beat(32'h7FFF, 32'h7FFF, 32'h7FFF, 32'h7FFF, 4'hF, 1, 32'h7FFF);
    drain();
    chk("sat_pos", 32'(sat_out), 1);
    pulse_clear();
    chk("sat_cleared", 32'(sat_out), 0);
    beat(-32768, -32768, -32768, -32768, 4'hF, 0, 0);
    beat(-32768, -32768, -32768, -32768, 4'hF, 1, 32'h8000);
    drain();
    chk("sat_neg", 32'(sat_out), 1);
    pulse_clear();

    // Masked lanes, then idle input
    num_groups = 8'd1;
    beat(100, 200, 300, 400, 4'b0101, 1, 400);
    drain();
    for (int i = 0; i < 3; i++) begin
      data = {16'd9, 16'd9, 16'd9, 16'd9}; valid = '0;
      @(posedge clk); #1;
      chk("idle_busy", 32'(busy_out), 0);
    end

    // Zero group count behaves as one; back-to-back single-group pixels
    num_groups = 8'd0;
    beat(1, 1, 1, 0, 4'hF, 1, 3);
    num_groups = 8'd1;
    beat(1, 0, 0, 0, 4'hF, 1, 1);
    beat(2, 0, 0, 0, 4'hF, 1, 2);
    drain();

    // Group count change mid-pixel is ignored
    num_groups = 8'd2;
    beat(5, 0, 0, 0, 4'hF, 0, 0);
    repeat (4) @(posedge clk);
    #1;
    num_groups = 8'd1;
    beat(6, 0, 0, 0, 4'hF, 1, 11);
    drain();

    // Clear mid-pixel, clear with a coincident beat, clear with a beat in flight
    num_groups = 8'd4;
    beat(1, 1, 1, 1, 4'hF, 0, 0);
    beat(1, 1, 1, 1, 4'hF, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("busy_partial", 32'(busy_out), 1);
    pulse_clear();
    chk("busy_after_clear", 32'(busy_out), 0);
    num_groups = 8'd1;
    clear = 1'b1;
    beat(7, 7, 7, 7, 4'hF, 0, 0);
    clear = 1'b0;
    beat(8, 8, 8, 8, 4'hF, 0, 0);
    pulse_clear();
    beat(2, 3, 4, 0, 4'hF, 1, 9);
    drain();
    chk("clear_sat", 32'(sat_out), 0);

    // Asynchronous reset mid-pixel
    num_groups = 8'd4;
    beat(3, 3, 3, 3, 4'hF, 0, 0);
    beat(3, 3, 3, 3, 4'hF, 0, 0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy_out), 0);
    chk("midrst_data", 32'(data_out), 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    num_groups = 8'd1;
    beat(4, 5, 0, 0, 4'hF, 1, 9);
    drain();
    chk("midrst_sat", 32'(sat_out), 0);

    // Negative result: clamped to zero only in the ReLU build
`ifdef CONV_CHAN_ACC_RELU_EN
    relu_exp = 0;
`else
    relu_exp = -50;
`endif
    beat(-10, -20, -15, -5, 4'hF, 1, relu_exp);
    drain();
    chk("relu_sat", 32'(sat_out), 0);

    chk("scoreboard_empty", 32'(sbq.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
